// File: rtl/dcache_refill_ctrl.sv
// Data-cache refill engine: optional dirty-victim write-back, then line fetch,
// then a one-cycle fill pulse to the cache. A watchdog parks the engine in ERR.
// reset_i is active-low and asynchronous.
module dcache_refill_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 128,
    parameter int OFFSET_W = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              miss_i,
    input  logic [ADDR_W-1:0] miss_addr_i,
    input  logic              victim_dirty_i,
    input  logic [ADDR_W-1:0] victim_addr_i,
    input  logic [LINE_W-1:0] victim_line_i,
    output logic              mem_req_o,
    output logic              mem_is_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ADDR_W-1:0] mem_write_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_read_ready_i,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_write_ack_i,
    output logic              busy_o,
    output logic              fill_valid_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [LINE_W-1:0] fill_line_o,
    output logic              timeout_err_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_REQ,
        S_RD_REQ,
        S_FILL,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic [ADDR_W-1:0] victim_addr_q, victim_addr_d;
    logic [LINE_W-1:0] victim_line_q, victim_line_d;
    logic [LINE_W-1:0] fill_line_q, fill_line_d;
    logic              wdog_expire;

    // The watchdog fires on the TIMEOUT-th waiting cycle, unless a response
    // arrives in that same cycle.
    assign wdog_expire = (wdog_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= S_IDLE;
            wdog_q        <= '0;
            miss_addr_q   <= '0;
            victim_addr_q <= '0;
            victim_line_q <= '0;
            fill_line_q   <= '0;
        end else begin
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            miss_addr_q   <= miss_addr_d;
            victim_addr_q <= victim_addr_d;
            victim_line_q <= victim_line_d;
            fill_line_q   <= fill_line_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wdog_d        = wdog_q;
        miss_addr_d   = miss_addr_q;
        victim_addr_d = victim_addr_q;
        victim_line_d = victim_line_q;
        fill_line_d   = fill_line_q;
        unique case (state_q)
            S_IDLE: begin
                if (miss_i) begin
                    miss_addr_d   = {miss_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    victim_addr_d = {victim_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    victim_line_d = victim_line_i;
                    wdog_d        = '0;
                    state_d       = victim_dirty_i ? S_WB_REQ : S_RD_REQ;
                end
            end
            S_WB_REQ: begin
                if (mem_write_ack_i) begin
                    wdog_d  = '0;
                    state_d = S_RD_REQ;
                end else if (wdog_expire) begin
                    wdog_d  = '0;
                    state_d = S_ERR;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_RD_REQ: begin
                if (mem_read_ready_i) begin
                    fill_line_d = mem_rdata_i;
                    wdog_d      = '0;
                    state_d     = S_FILL;
                end else if (wdog_expire) begin
                    wdog_d  = '0;
                    state_d = S_ERR;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_FILL: begin
                wdog_d  = '0;
                state_d = S_IDLE;
            end
            S_ERR: state_d = S_ERR;
            default: begin
                wdog_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Decoded straight from the state register so an async reset drops
    // mem_req/busy without waiting for a clock edge.
    assign mem_req_o        = (state_q == S_WB_REQ) || (state_q == S_RD_REQ);
    assign mem_is_write_o   = (state_q == S_WB_REQ);
    assign mem_addr_o       = miss_addr_q;
    assign mem_write_addr_o = victim_addr_q;
    assign mem_wdata_o      = victim_line_q;
    assign busy_o           = (state_q != S_IDLE);
    assign fill_valid_o     = (state_q == S_FILL);
    assign fill_addr_o      = miss_addr_q;
    assign fill_line_o      = fill_line_q;
    assign timeout_err_o    = (state_q == S_ERR);

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Randomized bench for dcache_refill_ctrl: each miss is scripted from the
// protocol rules (aligned addresses, handshake ordering, fill timing, watchdog).
module tb_dcache_refill_ctrl;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 128;
    localparam int OFFSET_W = 4;
    localparam int TIMEOUT  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              miss = 1'b0;
    logic [ADDR_W-1:0] miss_addr = '0;
    logic              victim_dirty = 1'b0;
    logic [ADDR_W-1:0] victim_addr = '0;
    logic [LINE_W-1:0] victim_line = '0;
    logic              mem_req, mem_is_write;
    logic [ADDR_W-1:0] mem_addr, mem_write_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_read_ready = 1'b0;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_write_ack = 1'b0;
    logic              busy, fill_valid, timeout_err;
    logic [ADDR_W-1:0] fill_addr;
    logic [LINE_W-1:0] fill_line;

    int n_chk = 0;
    int n_fail = 0;
    int fills = 0;
    int exp_fills = 0;

    dcache_refill_ctrl #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_W(OFFSET_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .miss_i(miss), .miss_addr_i(miss_addr),
        .victim_dirty_i(victim_dirty), .victim_addr_i(victim_addr), .victim_line_i(victim_line),
        .mem_req_o(mem_req), .mem_is_write_o(mem_is_write),
        .mem_addr_o(mem_addr), .mem_write_addr_o(mem_write_addr), .mem_wdata_o(mem_wdata),
        .mem_read_ready_i(mem_read_ready), .mem_rdata_i(mem_rdata), .mem_write_ack_i(mem_write_ack),
        .busy_o(busy), .fill_valid_o(fill_valid), .fill_addr_o(fill_addr),
        .fill_line_o(fill_line), .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (fill_valid === 1'b1) fills++;

    task automatic chk(input string tag, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return a & ~((32'd1 << OFFSET_W) - 32'd1);
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called just after a negedge with the bus idle; wk/rk are the waiting
    // cycle (1-based) on which the write ack / read data is returned.
    task automatic run_txn(input bit dirty, input logic [ADDR_W-1:0] maddr, input logic [ADDR_W-1:0] vaddr,
                           input logic [LINE_W-1:0] vline, input logic [LINE_W-1:0] rdata,
                           input int wk, input int rk, input bit noise);
        miss = 1'b1; miss_addr = maddr; victim_dirty = dirty;
        victim_addr = vaddr; victim_line = vline;
        @(negedge clk);
        miss = 1'b0; miss_addr = $urandom; victim_dirty = 1'($urandom);
        victim_addr = $urandom; victim_line = rnd_line();
        if (dirty) begin
            for (int c = 1; c <= wk; c++) begin
                chk("wb_req", mem_req, 1);
                chk("wb_is_write", mem_is_write, 1);
                chk("wb_addr", mem_write_addr, align(vaddr));
                chk("wb_data", mem_wdata, vline);
                chk("wb_no_fill", fill_valid, 0);
                chk("wb_busy", busy, 1);
                mem_write_ack = (c == wk);
                mem_read_ready = noise && ($urandom_range(0, 1) == 1);
                mem_rdata = rnd_line();
                @(negedge clk);
            end
            mem_write_ack = 1'b0; mem_read_ready = 1'b0;
        end
        for (int c = 1; c <= rk; c++) begin
            chk("rd_req", mem_req, 1);
            chk("rd_is_write", mem_is_write, 0);
            chk("rd_addr", mem_addr, align(maddr));
            chk("rd_no_fill", fill_valid, 0);
            mem_read_ready = (c == rk);
            mem_rdata = (c == rk) ? rdata : rnd_line();
            mem_write_ack = noise && ($urandom_range(0, 1) == 1);
            miss = noise && ($urandom_range(0, 1) == 1);
            miss_addr = $urandom; victim_dirty = 1'($urandom);
            @(negedge clk);
        end
        mem_read_ready = 1'b0; mem_write_ack = 1'b0; miss = 1'b0;
        chk("fill_valid", fill_valid, 1);
        chk("fill_addr", fill_addr, align(maddr));
        chk("fill_line", fill_line, rdata);
        chk("fill_req", mem_req, 0);
        chk("fill_busy", busy, 1);
        chk("fill_err", timeout_err, 0);
        exp_fills++;
        @(negedge clk);
        chk("idle_fill", fill_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_req", mem_req, 0);
    endtask

    task automatic run_timeout(input bit dirty);
        miss = 1'b1; miss_addr = $urandom; victim_dirty = dirty; victim_addr = $urandom;
        @(negedge clk);
        miss = 1'b0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            chk("to_wait_req", mem_req, 1);
            chk("to_wait_err", timeout_err, 0);
            @(negedge clk);
        end
        chk("to_err", timeout_err, 1);
        chk("to_req", mem_req, 0);
        chk("to_busy", busy, 1);
        mem_read_ready = 1'b1; mem_write_ack = 1'b1; miss = 1'b1;
        repeat (3) @(negedge clk);
        mem_read_ready = 1'b0; mem_write_ack = 1'b0; miss = 1'b0;
        chk("to_sticky", timeout_err, 1);
        chk("to_sticky_busy", busy, 1);
        chk("to_no_fill", fill_valid, 0);
        #2 reset = 1'b0;
        #1;
        chk("to_rst_err", timeout_err, 0);
        chk("to_rst_busy", busy, 0);
        chk("to_rst_req", mem_req, 0);
        chk("to_rst_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fill", fill_valid, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_fill_line", fill_line, 0);
        chk("rst_wdata", mem_wdata, 0);
        reset = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 32'h0000_1234, 32'h0, '0, 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF, 1, 4, 1'b0);
        run_txn(1'b1, 32'h0000_5678, 32'h0000_0A08, {4{32'h1111_1111}}, rnd_line(), 4, 4, 1'b0);
        run_txn(1'b1, 32'h0000_9ABC, 32'h0000_0C0F, rnd_line(), rnd_line(), 1, 1, 1'b1);
        run_txn(1'b1, $urandom, $urandom, rnd_line(), rnd_line(), TIMEOUT, TIMEOUT, 1'b1);

        // Async reset in the middle of a write-back, then a normal miss.
        miss = 1'b1; miss_addr = $urandom; victim_dirty = 1'b1; victim_addr = $urandom;
        victim_line = rnd_line();
        @(negedge clk);
        miss = 1'b0;
        @(negedge clk);
        chk("ar_req_before", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_req", mem_req, 0);
        chk("ar_busy", busy, 0);
        chk("ar_is_write", mem_is_write, 0);
        chk("ar_wdata", mem_wdata, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_txn(1'b0, $urandom, $urandom, rnd_line(), rnd_line(), 1, 3, 1'b1);

        for (int i = 0; i < 25; i++) begin
            run_txn(1'($urandom), $urandom, $urandom, rnd_line(), rnd_line(),
                    $urandom_range(1, TIMEOUT), $urandom_range(1, TIMEOUT), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        run_timeout(1'b0);
        run_timeout(1'b1);
        run_txn(1'b1, $urandom, $urandom, rnd_line(), rnd_line(), 2, 2, 1'b1);

        repeat (2) @(negedge clk);
        chk("fill_count", fills, exp_fills);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
- Cache-side initiator for the data-cache port of the memory controller.
- On a dcache miss, it writes back a dirty victim line if one exists, then fetches the missing line.
- Sequences the request/response handshake with the memory controller and delivers the fetched line to the cache in a single-cycle fill pulse.
- Includes a watchdog that flags a memory port that never responds.

Parameters:
ADDR_W, 32, byte address width (matches memory address length)
LINE_W, 128, cache line width in bits
OFFSET_W, 4, line offset bits; cleared in all issued addresses
TIMEOUT, 64, max cycles waiting for one memory response before error

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
miss  in  1  cache miss strobe; sampled only in IDLE
miss_addr  in  ADDR_W  address of missing access
victim_dirty  in  1  victim line must be written back
victim_addr  in  ADDR_W  victim line address
victim_line  in  LINE_W  victim line data
mem_req  out  1  request to memory controller (from_dcache)
mem_is_write  out  1  request is a write-back
mem_addr  out  ADDR_W  read address, line aligned
mem_write_addr  out  ADDR_W  write-back address, line aligned
mem_wdata  out  LINE_W  write-back data
mem_read_ready  in  1  memory read data valid
mem_rdata  in  LINE_W  memory read data
mem_write_ack  in  1  memory write completed
busy  out  1  engine not in IDLE
fill_valid  out  1  one-cycle pulse: fill_line/fill_addr valid
fill_addr  out  ADDR_W  aligned address of the filled line
fill_line  out  LINE_W  filled line data
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset (reset=0, async): state=IDLE; every output is 0, including timeout_err; internal registers are 0.
- Reset asserted mid-transaction aborts immediately and mem_req drops; no fill is issued.
- States: IDLE, WB_REQ, RD_REQ, FILL, ERR.
- IDLE:
  - On miss=1, latch miss_addr, victim_addr and victim_line, with the low OFFSET_W bits cleared in both addresses.
  - If victim_dirty=1, go to WB_REQ; otherwise go to RD_REQ.
  - Later changes on the cache inputs are ignored until the engine returns to IDLE.
- WB_REQ:
  - Outputs: mem_req=1, mem_is_write=1, mem_write_addr=latched victim address, mem_wdata=latched victim line.
  - On mem_write_ack=1, go to RD_REQ. mem_req stays 1 across the transition; mem_is_write falls the next cycle.
- RD_REQ:
  - Outputs: mem_req=1, mem_is_write=0, mem_addr=latched miss address.
  - On mem_read_ready=1, capture mem_rdata into fill_line and go to FILL.
- FILL:
  - fill_valid=1 for exactly one cycle; fill_addr=latched miss address; mem_req=0.
  - Next state is IDLE.
- Handshake rules:
  - mem_req is a level and is held, with stable address and data, until the matching response is observed.
  - In WB_REQ, mem_read_ready is ignored; in RD_REQ, mem_write_ack is ignored; both are ignored in IDLE.
  - mem_write_ack observed in the same cycle the write request first asserts is accepted.
- Watchdog:
  - Counter clears on every state entry and increments each cycle spent in WB_REQ or RD_REQ.
  - When it reaches TIMEOUT, go to ERR: timeout_err=1 (sticky), mem_req=0, busy=1.
  - Only reset leaves ERR.
- busy=1 in every state except IDLE.
- A miss with busy=1 is not accepted; the cache must hold off.
- Minimum miss-to-fill_valid latency:
  - clean victim: 2 + memory read latency cycles;
  - dirty victim: additionally plus memory write latency.
- Response arriving in the same cycle the watchdog reaches TIMEOUT: the response wins; no error.

Test Plan:
- Clean miss: reset, then miss=1, miss_addr=0x0000_1234, victim_dirty=0; memory returns 0xDEAD..BEEF after 4 cycles -> mem_addr=0x0000_1230, mem_is_write=0; fill_valid pulses one cycle later with fill_addr=0x0000_1230 and the exact data; busy returns to 0.
- Dirty miss: victim_addr=0x0000_0A08, victim_line=0x1111...; ack after 4 cycles, read after 4 more -> write request precedes read; mem_write_addr=0x0000_0A00 with the held data; then the read at the miss address and a correct fill.
- Busy rejection: second miss pulse during RD_REQ -> ignored; exactly one fill, carrying the first address.
- Spurious responses: mem_read_ready pulse during WB_REQ, and mem_write_ack during RD_REQ -> no state change, no fill.
- Timeout: TIMEOUT=8, memory never responds -> timeout_err=1 at cycle 8 of RD_REQ, mem_req=0, stays in ERR until reset low, then all outputs 0.
- Async reset mid-WB_REQ: reset low between clock edges -> mem_req and busy drop immediately without a clock edge; next miss proceeds normally.
